v_query_arb: RTL and testbench



---
 rtl/v_query_arb_if.sv | 56 +++++
 rtl/v_query_arb.sv | 153 +++++++++++++++
 tb/tb_v_query_arb.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_query_arb_if.sv
// Shared types for the list-query pipeline and the bundle of request,
// lookup and response signals between the clients/pipe and v_query_arb.
// The arbiter side uses modport slave; the client/pipe side uses modport master.

package v_pkg;
  typedef logic [15:0] id_t;
  typedef logic [3:0]  level_t;
  typedef logic [31:0] key_t;
  typedef logic [15:0] volume_t;
  typedef logic [7:0]  listsize_t;
endpackage

interface v_query_arb_if #(
  parameter int unsigned REQ_N = 4
);
  logic                          init_r;

  logic [REQ_N-1:0]              req_vld;
  v_pkg::id_t    [REQ_N-1:0]     req_prod_id;
  v_pkg::level_t [REQ_N-1:0]     req_level;
  logic [REQ_N-1:0]              req_rdy;

  logic                          lut_vld;
  v_pkg::id_t                    lut_prod_id;
  v_pkg::level_t                 lut_level;

  logic                          lut_vld_r;
  v_pkg::key_t                   lut_key;
  v_pkg::volume_t                lut_size;
  logic                          lut_error;
  v_pkg::listsize_t              lut_listsize;

  logic [REQ_N-1:0]              rsp_vld_r;
  v_pkg::key_t                   rsp_key_r;
  v_pkg::volume_t                rsp_size_r;
  logic                          rsp_error_r;
  v_pkg::listsize_t              rsp_listsize_r;

  modport slave (
    input  init_r,
    input  req_vld, req_prod_id, req_level,
    output req_rdy,
    output lut_vld, lut_prod_id, lut_level,
    input  lut_vld_r, lut_key, lut_size, lut_error, lut_listsize,
    output rsp_vld_r, rsp_key_r, rsp_size_r, rsp_error_r, rsp_listsize_r
  );

  modport master (
    output init_r,
    output req_vld, req_prod_id, req_level,
    input  req_rdy,
    input  lut_vld, lut_prod_id, lut_level,
    output lut_vld_r, lut_key, lut_size, lut_error, lut_listsize,
    input  rsp_vld_r, rsp_key_r, rsp_size_r, rsp_error_r, rsp_listsize_r
  );
endinterface

// File: rtl/v_query_arb.sv
// v_query_arb: round-robin scheduler sharing one list-query port among
// REQ_N clients. One request slot per client; results come back one cycle
// after issue and are routed to the issuing client as a registered pulse.
// Optional feature macro V_QUERY_ARB_RETRY_EN: when defined, erroring
// queries are re-issued up to RETRY_MAX times before the error is reported.

module v_query_arb #(
  parameter int unsigned REQ_N     = 4,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  v_query_arb_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(REQ_N);
  typedef logic [PTR_W-1:0] idx_t;

  if (REQ_N < 2 || REQ_N > 8 || RETRY_MAX < 1 || RETRY_MAX > 7) begin : g_bad_cfg
    $error("v_query_arb: REQ_N must be 2..8 and RETRY_MAX 1..7");
  end

  logic [REQ_N-1:0]          slot_vld;
  logic [REQ_N-1:0]          slot_inflight;
  v_pkg::id_t    [REQ_N-1:0] slot_prod_id;
  v_pkg::level_t [REQ_N-1:0] slot_level;

`ifdef V_QUERY_ARB_RETRY_EN
  localparam int unsigned CNT_W = $clog2(RETRY_MAX + 1);
  logic [REQ_N-1:0][CNT_W-1:0] retry_cnt;
`endif

  idx_t             rr_ptr;
  idx_t             tag_r;
  logic             tag_vld_r;

  logic [REQ_N-1:0] eligible;
  logic             grant_vld;
  idx_t             grant_idx;
  idx_t             cand;
  logic             res_hit;
  logic             res_done;

  assign eligible    = slot_vld & ~slot_inflight;
  assign bus.req_rdy = ~slot_vld;

  // Pick the first eligible slot at or after rr_ptr, wrapping; nothing during init
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < REQ_N; k++) begin
      cand = idx_t'((32'(rr_ptr) + k) % REQ_N);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (bus.init_r) begin
      grant_vld = 1'b0;
      grant_idx = '0;
    end
  end

  assign bus.lut_vld     = grant_vld;
  assign bus.lut_prod_id = slot_prod_id[grant_idx];
  assign bus.lut_level   = slot_level[grant_idx];

  // A result for the tagged slot either completes it or, with retry, sends it back to arbitration
  assign res_hit = bus.lut_vld_r & tag_vld_r;
`ifdef V_QUERY_ARB_RETRY_EN
  assign res_done = res_hit & (~bus.lut_error | (retry_cnt[tag_r] == CNT_W'(RETRY_MAX)));
`else
  assign res_done = res_hit;
`endif

  // Slot state: accept, mark in flight on grant, and resolve on result or dropped issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld      <= '0;
      slot_inflight <= '0;
      slot_prod_id  <= '0;
      slot_level    <= '0;
`ifdef V_QUERY_ARB_RETRY_EN
      retry_cnt     <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < REQ_N; i++) begin
        if (bus.req_vld[i] && !slot_vld[i]) begin
          slot_vld[i]      <= 1'b1;
          slot_inflight[i] <= 1'b0;
          slot_prod_id[i]  <= bus.req_prod_id[i];
          slot_level[i]    <= bus.req_level[i];
`ifdef V_QUERY_ARB_RETRY_EN
          retry_cnt[i]     <= '0;
`endif
        end
        if (grant_vld && grant_idx == idx_t'(i)) begin
          slot_inflight[i] <= 1'b1;
        end
        // A missing result (tag set, no result) just re-arms the slot
        if (tag_vld_r && tag_r == idx_t'(i)) begin
          slot_inflight[i] <= 1'b0;
          if (res_done) begin
            slot_vld[i] <= 1'b0;
          end
`ifdef V_QUERY_ARB_RETRY_EN
          else if (res_hit) begin
            retry_cnt[i] <= retry_cnt[i] + 1'b1;
          end
`endif
        end
      end
    end
  end

  // Remember which slot was issued so the next-cycle result can be routed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      tag_r     <= '0;
      tag_vld_r <= 1'b0;
    end else begin
      tag_vld_r <= grant_vld;
      if (grant_vld) begin
        tag_r  <= grant_idx;
        rr_ptr <= idx_t'((32'(grant_idx) + 1) % REQ_N);
      end
    end
  end

  // Registered one-hot response strobe and payload capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_vld_r      <= '0;
      bus.rsp_key_r      <= '0;
      bus.rsp_size_r     <= '0;
      bus.rsp_error_r    <= 1'b0;
      bus.rsp_listsize_r <= '0;
    end else begin
      for (int unsigned i = 0; i < REQ_N; i++) begin
        bus.rsp_vld_r[i] <= res_done && (tag_r == idx_t'(i));
      end
      if (res_done) begin
        bus.rsp_key_r      <= bus.lut_key;
        bus.rsp_size_r     <= bus.lut_size;
        bus.rsp_error_r    <= bus.lut_error;
        bus.rsp_listsize_r <= bus.lut_listsize;
      end
    end
  end

endmodule

// File: tb/tb_v_query_arb.sv
// Scoreboard bench for v_query_arb: directed requests push expected
// responses; a monitor pops and compares whenever a response pulse appears.
// A small pipe model answers each issue one cycle later with
// key = id*10 + level*4 (OR 0xE0000000 on an injected error),
// size = id*3 + level, listsize = id + level.

module tb_v_query_arb;
  import v_pkg::*;

  localparam int unsigned REQ_N = 4;

`ifdef V_QUERY_ARB_RETRY_EN
  localparam int RETRY_EN = 1;
`else
  localparam int RETRY_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  v_query_arb_if #(.REQ_N(REQ_N)) bus ();

  v_query_arb #(.REQ_N(REQ_N), .RETRY_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] onehot;
    key_t       key;
    volume_t    size;
    logic       err;
    listsize_t  ls;
  } rsp_t;

  typedef struct {
    int  cyc;
    id_t id;
  } issue_t;

  rsp_t   exp_q[$];
  issue_t issue_log[$];
  rsp_t   e;

  id_t err_id   = 16'hFFFF;
  int  err_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int c, input id_t id, input level_t lvl);
    bus.req_vld[c]     = 1'b1;
    bus.req_prod_id[c] = id;
    bus.req_level[c]   = lvl;
  endtask

  task automatic expect_rsp(input logic [3:0] oh, input key_t k, input volume_t s,
                            input logic er, input listsize_t ls);
    rsp_t r;
    r.onehot = oh; r.key = k; r.size = s; r.err = er; r.ls = ls;
    exp_q.push_back(r);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_vld = '0;
    bus.init_r  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    issue_log.delete();
  endtask

  // Pipe model: sample issue mid-cycle, answer just after the next edge
  initial begin
    logic    s_vld;
    id_t     s_id;
    level_t  s_lvl;
    logic    s_err;
    bus.lut_vld_r    = 1'b0;
    bus.lut_key      = '0;
    bus.lut_size     = '0;
    bus.lut_error    = 1'b0;
    bus.lut_listsize = '0;
    forever begin
      @(negedge clk);
      s_vld = bus.lut_vld;
      s_id  = bus.lut_prod_id;
      s_lvl = bus.lut_level;
      if (s_vld && !rst) issue_log.push_back('{cyc, s_id});
      @(posedge clk);
      #1;
      bus.lut_vld_r = s_vld;
      s_err = 1'b0;
      if (s_vld && s_id == err_id && err_left > 0) begin
        s_err = 1'b1;
        err_left--;
      end
      bus.lut_error    = s_err;
      bus.lut_key      = (32'(s_id) * 10 + 32'(s_lvl) * 4) | (s_err ? 32'hE000_0000 : 32'h0);
      bus.lut_size     = 16'(32'(s_id) * 3 + 32'(s_lvl));
      bus.lut_listsize = 8'(32'(s_id) + 32'(s_lvl));
    end
  end

  // Monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.rsp_vld_r != '0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rsp_vld_r=%b, required no response", bus.rsp_vld_r);
      end else begin
        e = exp_q.pop_front();
        check("rsp_onehot",   64'(bus.rsp_vld_r),      64'(e.onehot));
        check("rsp_key",      64'(bus.rsp_key_r),      64'(e.key));
        check("rsp_size",     64'(bus.rsp_size_r),     64'(e.size));
        check("rsp_error",    64'(bus.rsp_error_r),    64'(e.err));
        check("rsp_listsize", 64'(bus.rsp_listsize_r), 64'(e.ls));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    bus.init_r      = 1'b0;
    bus.req_vld     = '0;
    bus.req_prod_id = '0;
    bus.req_level   = '0;

    // Reset state
    tick();
    tick();
    check("reset_rdy",     64'(bus.req_rdy),     64'hF);
    check("reset_lut_vld", 64'(bus.lut_vld),     64'd0);
    check("reset_rsp_vld", 64'(bus.rsp_vld_r),   64'd0);
    check("reset_rsp_key", 64'(bus.rsp_key_r),   64'd0);
    check("reset_rsp_err", 64'(bus.rsp_error_r), 64'd0);
    rst = 1'b0;

    // Single request, minimum latency
    request(0, 16'd5, 4'd2);
    expect_rsp(4'b0001, 32'h3A, 16'd17, 1'b0, 8'd7);
    tick();
    bus.req_vld = '0;
    check("t1_issue_vld", 64'(bus.lut_vld),     64'd1);
    check("t1_issue_id",  64'(bus.lut_prod_id), 64'd5);
    tick();
    tick();
    check("t1_rsp_at_t3", 64'(bus.rsp_vld_r), 64'b0001);
    tick();
    check("t1_rdy_at_t4", 64'(bus.req_rdy), 64'hF);
    wait_drain("t1_drain");

    // All four at once from rr_ptr = 0
    do_reset();
    request(0, 16'd1, 4'd0);
    request(1, 16'd2, 4'd1);
    request(2, 16'd3, 4'd2);
    request(3, 16'd4, 4'd3);
    expect_rsp(4'b0001, 32'h0A, 16'd3,  1'b0, 8'd1);
    expect_rsp(4'b0010, 32'h18, 16'd7,  1'b0, 8'd3);
    expect_rsp(4'b0100, 32'h26, 16'd11, 1'b0, 8'd5);
    expect_rsp(4'b1000, 32'h34, 16'd15, 1'b0, 8'd7);
    tick();
    bus.req_vld = '0;
    wait_drain("t2_drain");
    check("t2_issue_count", 64'(issue_log.size()), 64'd4);
    if (issue_log.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check("t2_issue_order", 64'(issue_log[j].id), 64'(j + 1));
        check("t2_issue_cycle", 64'(issue_log[j].cyc - issue_log[0].cyc), 64'(j));
      end
    end

    // Issue held off during table initialization
    bus.init_r = 1'b1;
    request(2, 16'd9, 4'd1);
    expect_rsp(4'b0100, 32'h5E, 16'd28, 1'b0, 8'd10);
    tick();
    bus.req_vld = '0;
    for (int j = 0; j < 5; j++) begin
      check("t3_no_issue_in_init", 64'(bus.lut_vld), 64'd0);
      tick();
    end
    bus.init_r = 1'b0;
    #1;
    check("t3_issue_after_init", 64'(bus.lut_vld),     64'd1);
    check("t3_issue_id",         64'(bus.lut_prod_id), 64'd9);
    wait_drain("t3_drain");

    // Pipe always errors for client 1
    issue_log.delete();
    err_id   = 16'd7;
    err_left = 1000;
    request(1, 16'd7, 4'd0);
    expect_rsp(4'b0010, 32'hE000_0046, 16'd21, 1'b1, 8'd7);
    tick();
    bus.req_vld = '0;
    wait_drain("t4_drain");
    err_id = 16'hFFFF;
    check("t4_issue_count", 64'(issue_log.size()), 64'(RETRY_EN != 0 ? 4 : 1));
    for (int j = 1; j < issue_log.size(); j++) begin
      check("t4_issue_gap_ge2", 64'((issue_log[j].cyc - issue_log[j-1].cyc) >= 2), 64'd1);
    end

    // Error on the first attempt only
    issue_log.delete();
    err_id   = 16'd6;
    err_left = 1;
    request(0, 16'd6, 4'd1);
    if (RETRY_EN != 0) expect_rsp(4'b0001, 32'h40, 16'd19, 1'b0, 8'd7);
    else               expect_rsp(4'b0001, 32'hE000_0040, 16'd19, 1'b1, 8'd7);
    tick();
    bus.req_vld = '0;
    wait_drain("t5_drain");
    err_id = 16'hFFFF;
    check("t5_issue_count", 64'(issue_log.size()), 64'(RETRY_EN != 0 ? 2 : 1));

    // Reset lands in the cycle the result returns
    request(3, 16'd2, 4'd2);
    tick();
    bus.req_vld = '0;
    check("t6_issue_vld", 64'(bus.lut_vld), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      check("t6_no_rsp",  64'(bus.rsp_vld_r), 64'd0);
      check("t6_rdy",     64'(bus.req_rdy),   64'hF);
      check("t6_no_issue", 64'(bus.lut_vld),  64'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
